// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART deframer oversampling the rx pin at 4x baud.
// Each good byte is presented on rx_byte with a one-cycle received strobe;
// a zero stop bit gives a one-cycle recv_error strobe instead.
module uart_receiver #(
  parameter int unsigned CLOCK_DIVIDE = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       received,
  output logic       is_receiving,
  output logic       recv_error
);

  localparam int unsigned DW = ($clog2(CLOCK_DIVIDE) < 1) ? 1 : $clog2(CLOCK_DIVIDE);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLOCK_DIVIDE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  logic          rx_meta_q, rx_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          received_q, received_d;
  logic          recv_error_q, recv_error_d;
  logic          is_receiving_q, is_receiving_d;

  logic tick;
  logic mid_start;
  logic bit_point;

  assign tick      = (div_q == DIV_MAX);
  assign mid_start = tick && (tcnt_q == 2'd1);
  assign bit_point = tick && (tcnt_q == 2'd3);

  assign rx_byte      = rx_byte_q;
  assign received     = received_q;
  assign is_receiving = is_receiving_q;
  assign recv_error   = recv_error_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decisions, all taken from the synchronised pin.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!rx_s_q) state_d = START;
      START:     if (mid_start) state_d = rx_s_q ? IDLE : DATA;
      DATA:      if (bit_point && (bcnt_q == 3'd7)) state_d = STOP;
      STOP:      if (bit_point) state_d = rx_s_q ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    div_d          = div_q;
    tcnt_d         = tcnt_q;
    bcnt_d         = bcnt_q;
    shift_d        = shift_q;
    rx_byte_d      = rx_byte_q;
    received_d     = 1'b0;
    recv_error_d   = 1'b0;
    is_receiving_d = (state_d != IDLE);

    // Divider restarts on the start edge so bit timing is phase-aligned to it.
    if ((state_d == IDLE) || ((state_d == START) && (state_q != START)))
      div_d = '0;
    else if (tick)
      div_d = '0;
    else
      div_d = div_q + 1'b1;

    if (state_d != state_q)
      tcnt_d = '0;
    else if (tick)
      tcnt_d = tcnt_q + 2'd1;

    unique case (state_q)
      START: begin
        if (mid_start && !rx_s_q) bcnt_d = '0;
      end
      DATA: begin
        if (bit_point) begin
          shift_d[bcnt_q] = rx_s_q;
          if (bcnt_q != 3'd7) bcnt_d = bcnt_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_point) begin
          if (rx_s_q) begin
            rx_byte_d  = shift_q;
            received_d = 1'b1;
          end else begin
            recv_error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Synchroniser, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      div_q          <= '0;
      tcnt_q         <= '0;
      bcnt_q         <= '0;
      shift_q        <= '0;
      rx_byte_q      <= '0;
      received_q     <= 1'b0;
      recv_error_q   <= 1'b0;
      is_receiving_q <= 1'b0;
    end else begin
      rx_meta_q      <= rx;
      rx_s_q         <= rx_meta_q;
      div_q          <= div_d;
      tcnt_q         <= tcnt_d;
      bcnt_q         <= bcnt_d;
      shift_q        <= shift_d;
      rx_byte_q      <= rx_byte_d;
      received_q     <= received_d;
      recv_error_q   <= recv_error_d;
      is_receiving_q <= is_receiving_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed, table-driven bench for uart_receiver at CLOCK_DIVIDE=4 (16 clk per bit).
module tb_uart_receiver;

  localparam int unsigned BIT = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       received;
  logic       is_receiving;
  logic       recv_error;

  uart_receiver #(.CLOCK_DIVIDE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .received     (received),
    .is_receiving (is_receiving),
    .recv_error   (recv_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event monitor, sampling 1 time unit after each rising edge.
  int   cyc = 0;
  int   rcv_cnt = 0;
  int   err_cnt = 0;
  int   start_cnt = 0;
  int   t_start = 0;
  int   t_rcv = 0;
  logic prev_busy = 1'b0;
  logic prev_rcv = 1'b0;
  logic prev_err = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (is_receiving === 1'b1 && prev_busy !== 1'b1) begin
      start_cnt++;
      t_start = cyc;
    end
    if (received === 1'b1) begin
      rcv_cnt++;
      t_rcv = cyc;
      chk("strobe_excl", {31'b0, recv_error}, 32'd0);
      chk("busy_falls_with_rcv", {31'b0, is_receiving}, 32'd0);
      chk("rcv_one_cycle", {31'b0, prev_rcv}, 32'd0);
    end
    if (recv_error === 1'b1) begin
      err_cnt++;
      chk("err_one_cycle", {31'b0, prev_err}, 32'd0);
    end
    prev_busy = is_receiving;
    prev_rcv  = received;
    prev_err  = recv_error;
  end

  task automatic wait_cyc(input int unsigned n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
    rx = stop_bit;
    wait_cyc(BIT);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop_bit;
    int unsigned hold_low;
    int unsigned idle_after;
    logic [7:0]  exp_byte;
    int unsigned exp_rcv;
    int unsigned exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rcv0, err0, st0;

    vecs[0] = '{8'hA5, 1'b1, 0,   20, 8'hA5, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0,   0,  8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0,   0,  8'hFF, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 0,   20, 8'h3C, 1, 0};
    vecs[4] = '{8'h5A, 1'b0, 200, 20, 8'h3C, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 0,   20, 8'h81, 1, 0};

    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(3);
    chk("reset_rx_byte", {24'b0, rx_byte}, 32'h00);
    chk("reset_received", {31'b0, received}, 32'd0);
    chk("reset_busy", {31'b0, is_receiving}, 32'd0);
    chk("reset_err", {31'b0, recv_error}, 32'd0);
    rst = 1'b0;
    wait_cyc(100);
    chk("idle_no_rcv", rcv_cnt, 32'd0);
    chk("idle_no_err", err_cnt, 32'd0);
    chk("idle_no_start", start_cnt, 32'd0);

    for (int i = 0; i < 6; i++) begin
      rcv0 = rcv_cnt;
      err0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit);
      if (vecs[i].hold_low > 0) begin
        rx = 1'b0;
        wait_cyc(vecs[i].hold_low);
      end
      rx = 1'b1;
      wait_cyc(vecs[i].idle_after);
      chk($sformatf("vec%0d_byte", i), {24'b0, rx_byte}, {24'b0, vecs[i].exp_byte});
      chk($sformatf("vec%0d_rcv_count", i), rcv_cnt - rcv0, vecs[i].exp_rcv);
      chk($sformatf("vec%0d_err_count", i), err_cnt - err0, vecs[i].exp_err);
      if (i == 0) chk("start_to_rcv_cycles", ((t_rcv - t_start) >= 151 && (t_rcv - t_start) <= 153) ? 1 : 0, 32'd1);
    end

    // Three-cycle glitch on idle line.
    rcv0 = rcv_cnt;
    err0 = err_cnt;
    st0  = start_cnt;
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(40);
    chk("glitch_start_seen", start_cnt - st0, 32'd1);
    chk("glitch_busy_low", {31'b0, is_receiving}, 32'd0);
    chk("glitch_no_rcv", rcv_cnt - rcv0, 32'd0);
    chk("glitch_no_err", err_cnt - err0, 32'd0);
    chk("glitch_byte_kept", {24'b0, rx_byte}, 32'h81);

    // Asynchronous reset during data bit 4 of 0xC3.
    rcv0 = rcv_cnt;
    err0 = err_cnt;
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 1'b1;
      wait_cyc(BIT);
    end
    rx = 1'b0;
    wait_cyc(8);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_rx_byte", {24'b0, rx_byte}, 32'h00);
    chk("midreset_busy", {31'b0, is_receiving}, 32'd0);
    chk("midreset_received", {31'b0, received}, 32'd0);
    chk("midreset_err", {31'b0, recv_error}, 32'd0);
    @(posedge clk);
    #2;
    rx = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(40);
    chk("abort_no_rcv", rcv_cnt - rcv0, 32'd0);
    chk("abort_no_err", err_cnt - err0, 32'd0);
    send_frame(8'h12, 1'b1);
    wait_cyc(20);
    chk("after_reset_byte", {24'b0, rx_byte}, 32'h12);
    chk("after_reset_rcv", rcv_cnt - rcv0, 32'd1);
    chk("after_reset_err", err_cnt - err0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
